// File: rtl/hier_icache_pkg.sv
// Shared types for the hierarchical instruction-cache flush sequencer:
// command op-codes, sequencer states and op-code decode helpers.
package hier_icache_pkg;

  typedef enum logic [2:0] {
    FLUSH_L1  = 3'd0,
    FLUSH_L2  = 3'd1,
    FLUSH_ALL = 3'd2,
    SEL_L1    = 3'd3,
    SEL_L2    = 3'd4,
    SEL_ALL   = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    L2_PH = 2'd1,
    L1_PH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Codes 6 and 7 have no meaning and complete immediately with an error.
  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

  function automatic logic op_has_l2(input logic [2:0] op);
    case (op)
      FLUSH_L2, FLUSH_ALL, SEL_L2, SEL_ALL: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic op_has_l1(input logic [2:0] op);
    case (op)
      FLUSH_L1, FLUSH_ALL, SEL_L1, SEL_ALL: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_sel(input logic [2:0] op);
    case (op)
      SEL_L1, SEL_L2, SEL_ALL: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hier_icache_flush_seq_if.sv
// Request/acknowledge bundle between the flush sequencer and one cache
// level; the sequencer is the master, the caches are the slave.
interface hier_icache_flush_seq_if #(
  parameter int N = 4
);

  logic [N-1:0] full_req;
  logic [N-1:0] sel_req;
  logic [N-1:0] full_ack;
  logic [N-1:0] sel_ack;

  modport master (
    output full_req,
    output sel_req,
    input  full_ack,
    input  sel_ack
  );

  modport slave (
    input  full_req,
    input  sel_req,
    output full_ack,
    output sel_ack
  );

endinterface

// File: rtl/hier_icache_ack_collector.sv
// Pending-target vector and per-phase timeout counter for one cache level.
// Requests are driven straight from the pending flops.
module hier_icache_ack_collector #(
  parameter int N              = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic [N-1:0] load_mask,
  input  logic         active,
  input  logic         sel,
  hier_icache_flush_seq_if.master bus,
  output logic         phase_done,
  output logic         timeout
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [N-1:0]  pending_q;
  logic [N-1:0]  acked;
  logic [N-1:0]  pending_acked;
  logic [CW-1:0] cnt_q;

  // Only the ack type matching the current request type counts; an ack on a
  // target that is not pending is masked off here.
  assign acked         = sel ? bus.sel_ack : bus.full_ack;
  assign pending_acked = pending_q & ~acked;

  // Completion looks through this cycle's acks so a phase whose targets all
  // answer in its first cycle lasts exactly one cycle.
  assign phase_done = (pending_acked == '0);
  assign timeout    = !phase_done && (cnt_q == CNT_LAST);

  assign bus.full_req = sel ? '0 : pending_q;
  assign bus.sel_req  = sel ? pending_q : '0;

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else if (load) begin
      pending_q <= load_mask;
      cnt_q     <= '0;
    end else begin
      pending_q <= timeout ? '0 : pending_acked;
      cnt_q     <= active ? cnt_q + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/hier_icache_flush_seq.sv
// Hierarchical I-cache flush sequencer: accepts one flush command, flushes
// the shared L2 banks and/or the private L1s in order, then reports done/err.
module hier_icache_flush_seq
  import hier_icache_pkg::*;
#(
  parameter int NB_CORES       = 9,
  parameter int NB_CACHE_BANKS = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [2:0]                cmd_op_i,
  input  logic [NB_CORES-1:0]       cmd_core_mask_i,
  input  logic [31:0]               cmd_addr_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [NB_CORES-1:0]       L1_flush_req_o,
  input  logic [NB_CORES-1:0]       L1_flush_ack_i,
  output logic [NB_CORES-1:0]       L1_sel_flush_req_o,
  input  logic [NB_CORES-1:0]       L1_sel_flush_ack_i,
  output logic [NB_CACHE_BANKS-1:0] L2_flush_req_o,
  input  logic [NB_CACHE_BANKS-1:0] L2_flush_ack_i,
  output logic [NB_CACHE_BANKS-1:0] L2_sel_flush_req_o,
  input  logic [NB_CACHE_BANKS-1:0] L2_sel_flush_ack_i,
  output logic [31:0]               sel_flush_addr_o
);

  state_e              state_q, state_d;
  logic [2:0]          op_q;
  logic [NB_CORES-1:0] mask_q;
  logic [31:0]         addr_q;
  logic                err_q;
  logic                err_set;
  logic                accept;
  logic                sel;

  logic                l2_load, l2_active, l2_done, l2_timeout;
  logic                l1_load, l1_active, l1_done, l1_timeout;
  logic [NB_CORES-1:0] l1_load_mask;

  hier_icache_flush_seq_if #(.N(NB_CACHE_BANKS)) l2_bus ();
  hier_icache_flush_seq_if #(.N(NB_CORES))       l1_bus ();

  assign l2_bus.full_ack    = L2_flush_ack_i;
  assign l2_bus.sel_ack     = L2_sel_flush_ack_i;
  assign L2_flush_req_o     = l2_bus.full_req;
  assign L2_sel_flush_req_o = l2_bus.sel_req;
  assign l1_bus.full_ack    = L1_flush_ack_i;
  assign l1_bus.sel_ack     = L1_sel_flush_ack_i;
  assign L1_flush_req_o     = l1_bus.full_req;
  assign L1_sel_flush_req_o = l1_bus.sel_req;

  assign accept           = cmd_valid_i && (state_q == IDLE);
  assign sel              = op_is_sel(op_q);
  assign l2_active        = (state_q == L2_PH);
  assign l1_active        = (state_q == L1_PH);
  assign sel_flush_addr_o = addr_q;

  // L1-only commands load the L1 phase straight from the command inputs.
  assign l1_load_mask = (state_q == IDLE) ? cmd_core_mask_i : mask_q;

  hier_icache_ack_collector #(
    .N              (NB_CACHE_BANKS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_l2_collector (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load       (l2_load),
    .load_mask  ({NB_CACHE_BANKS{1'b1}}),
    .active     (l2_active),
    .sel        (sel),
    .bus        (l2_bus),
    .phase_done (l2_done),
    .timeout    (l2_timeout)
  );

  hier_icache_ack_collector #(
    .N              (NB_CORES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_l1_collector (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load       (l1_load),
    .load_mask  (l1_load_mask),
    .active     (l1_active),
    .sel        (sel),
    .bus        (l1_bus),
    .phase_done (l1_done),
    .timeout    (l1_timeout)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    err_o       = 1'b0;
    err_set     = 1'b0;
    l2_load     = 1'b0;
    l1_load     = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_valid_i) begin
          if (!op_legal(cmd_op_i)) begin
            state_d = DONE;
            err_set = 1'b1;
          end else if (op_has_l2(cmd_op_i)) begin
            state_d = L2_PH;
            l2_load = 1'b1;
          end else if (cmd_core_mask_i != '0) begin
            state_d = L1_PH;
            l1_load = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end

      L2_PH: begin
        if (l2_timeout) begin
          state_d = DONE;
          err_set = 1'b1;
        end else if (l2_done) begin
          if (op_has_l1(op_q) && (mask_q != '0)) begin
            state_d = L1_PH;
            l1_load = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end

      L1_PH: begin
        if (l1_timeout) begin
          state_d = DONE;
          err_set = 1'b1;
        end else if (l1_done) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= cmd_op_i;
        mask_q <= cmd_core_mask_i;
        addr_q <= cmd_addr_i;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end else if (state_q == DONE) begin
        err_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hier_icache_flush_seq.sv
// Randomized bench for hier_icache_flush_seq: each command's per-cycle
// request/done timeline is derived from the op decode table and ack delays.
module tb_hier_icache_flush_seq;

  localparam int N_CORES = 9;
  localparam int N_BANKS = 4;
  localparam int T_OUT   = 16;
  localparam int NEVER   = 1_000_000;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          cmd_op;
  logic [N_CORES-1:0]  cmd_mask;
  logic [31:0]         cmd_addr;
  logic                busy, done, err;
  logic [31:0]         sel_addr;

  hier_icache_flush_seq_if #(.N(N_CORES)) l1_bus ();
  hier_icache_flush_seq_if #(.N(N_BANKS)) l2_bus ();

  int dly2 [N_BANKS];
  int dly1 [N_CORES];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hier_icache_flush_seq #(
    .NB_CORES       (N_CORES),
    .NB_CACHE_BANKS (N_BANKS),
    .TIMEOUT_CYCLES (T_OUT)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .cmd_valid_i        (cmd_valid),
    .cmd_ready_o        (cmd_ready),
    .cmd_op_i           (cmd_op),
    .cmd_core_mask_i    (cmd_mask),
    .cmd_addr_i         (cmd_addr),
    .busy_o             (busy),
    .done_o             (done),
    .err_o              (err),
    .L1_flush_req_o     (l1_bus.full_req),
    .L1_flush_ack_i     (l1_bus.full_ack),
    .L1_sel_flush_req_o (l1_bus.sel_req),
    .L1_sel_flush_ack_i (l1_bus.sel_ack),
    .L2_flush_req_o     (l2_bus.full_req),
    .L2_flush_ack_i     (l2_bus.full_ack),
    .L2_sel_flush_req_o (l2_bus.sel_req),
    .L2_sel_flush_ack_i (l2_bus.sel_ack),
    .sel_flush_addr_o   (sel_addr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_acks();
    l1_bus.full_ack = '0;
    l1_bus.sel_ack  = '0;
    l2_bus.full_ack = '0;
    l2_bus.sel_ack  = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " l2_full"}, l2_bus.full_req, 0);
    check({tag, " l2_sel"},  l2_bus.sel_req,  0);
    check({tag, " l1_full"}, l1_bus.full_req, 0);
    check({tag, " l1_sel"},  l1_bus.sel_req,  0);
    check({tag, " done"},    done, 0);
    check({tag, " err"},     err,  0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // first idle cycle after completion. Ack delays come from dly2/dly1:
  // target i acks d cycles after its request rises (NEVER = no ack).
  task automatic run_cmd(input logic [2:0] op, input logic [N_CORES-1:0] mask,
                         input logic [31:0] addr, input bit hold);
    bit legal, has1, has2, is_sel, err_e;
    int s2, len2, s1, len1, total, maxd;
    logic [N_BANKS-1:0] e2, a2;
    logic [N_CORES-1:0] e1, a1;

    legal  = (op <= 3'd5);
    has2   = (op inside {3'd1, 3'd2, 3'd4, 3'd5});
    has1   = (op inside {3'd0, 3'd2, 3'd3, 3'd5});
    is_sel = (op inside {3'd3, 3'd4, 3'd5});
    err_e  = !legal;
    s2 = -1; len2 = 0; s1 = -1; len1 = 0; total = 0;

    if (legal && has2) begin
      maxd = 0;
      for (int b = 0; b < N_BANKS; b++) if (dly2[b] > maxd) maxd = dly2[b];
      s2 = 0;
      if (maxd + 1 > T_OUT) begin len2 = T_OUT; err_e = 1'b1; end
      else len2 = maxd + 1;
      total = len2;
    end
    if (legal && has1 && mask != '0 && !err_e) begin
      maxd = 0;
      for (int i = 0; i < N_CORES; i++) if (mask[i] && dly1[i] > maxd) maxd = dly1[i];
      s1 = total;
      if (maxd + 1 > T_OUT) begin len1 = T_OUT; err_e = 1'b1; end
      else len1 = maxd + 1;
      total += len1;
    end

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_addr  = addr;
    check("ready_at_issue", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);

    for (int c = 0; c <= total + 1; c++) begin
      e2 = '0;
      e1 = '0;
      if (s2 >= 0 && c < s2 + len2)
        for (int b = 0; b < N_BANKS; b++) e2[b] = ((c - s2) <= dly2[b]);
      if (s1 >= 0 && c >= s1 && c < s1 + len1)
        for (int i = 0; i < N_CORES; i++) e1[i] = mask[i] && ((c - s1) <= dly1[i]);

      check($sformatf("op%0d c%0d l2_full", op, c), l2_bus.full_req, is_sel ? '0 : e2);
      check($sformatf("op%0d c%0d l2_sel",  op, c), l2_bus.sel_req,  is_sel ? e2 : '0);
      check($sformatf("op%0d c%0d l1_full", op, c), l1_bus.full_req, is_sel ? '0 : e1);
      check($sformatf("op%0d c%0d l1_sel",  op, c), l1_bus.sel_req,  is_sel ? e1 : '0);
      check($sformatf("op%0d c%0d done",    op, c), done,  c == total);
      check($sformatf("op%0d c%0d err",     op, c), err,   (c == total) && err_e);
      check($sformatf("op%0d c%0d busy",    op, c), busy,  c <= total);
      check($sformatf("op%0d c%0d ready",   op, c), cmd_ready, c == total + 1);
      if (c <= total) check($sformatf("op%0d c%0d addr", op, c), sel_addr, addr);
      if (c == total + 1) break;

      // Held valid with junk fields must be ignored while busy.
      if (hold) begin
        cmd_valid = 1'b1;
        cmd_op    = 3'($urandom);
        cmd_mask  = N_CORES'($urandom);
        cmd_addr  = $urandom;
      end else begin
        cmd_valid = 1'b0;
      end

      // Pending targets ack exactly at their delay; everything else is noise
      // that must be ignored.
      a2 = N_BANKS'($urandom) & ~e2;
      a1 = N_CORES'($urandom) & ~e1;
      for (int b = 0; b < N_BANKS; b++) if (e2[b] && (c - s2) == dly2[b]) a2[b] = 1'b1;
      for (int i = 0; i < N_CORES; i++) if (e1[i] && (c - s1) == dly1[i]) a1[i] = 1'b1;
      if (is_sel) begin
        l2_bus.sel_ack  = a2;  l2_bus.full_ack = N_BANKS'($urandom);
        l1_bus.sel_ack  = a1;  l1_bus.full_ack = N_CORES'($urandom);
      end else begin
        l2_bus.full_ack = a2;  l2_bus.sel_ack  = N_BANKS'($urandom);
        l1_bus.full_ack = a1;  l1_bus.sel_ack  = N_CORES'($urandom);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    clear_acks();
  endtask

  task automatic set_delays(input int d2, input int d1);
    for (int b = 0; b < N_BANKS; b++) dly2[b] = d2;
    for (int i = 0; i < N_CORES; i++) dly1[i] = d1;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_mask  = '0;
    cmd_addr  = '0;
    clear_acks();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    check("reset busy",  busy, 0);
    check("reset ready", cmd_ready, 1);
    check("reset addr",  sel_addr, 0);
    rst = 1'b0;

    // All levels, every target answers.
    set_delays(3, 2);
    run_cmd(3'd2, 9'h1FF, 32'hA5A5_0000, 1'b0);

    // Selective L1 on cores 0 and 2 with staggered acks.
    set_delays(NEVER, NEVER);
    dly1[0] = 2;
    dly1[2] = 5;
    run_cmd(3'd3, 9'h005, 32'h1C00_8000, 1'b0);

    // L2 bank 3 never answers: phase aborts at the timeout.
    set_delays(1, 1);
    dly2[3] = NEVER;
    run_cmd(3'd1, 9'h000, 32'h0000_1234, 1'b0);

    // Illegal op.
    run_cmd(3'd7, 9'h1FF, 32'hDEAD_BEEF, 1'b0);

    // Empty L1 mask with valid held, then a back-to-back command.
    run_cmd(3'd0, 9'h000, 32'h0000_0040, 1'b1);
    set_delays(0, 1);
    run_cmd(3'd0, 9'h0F0, 32'h0000_0080, 1'b0);

    // Timeout in L2 of a two-level op must skip L1 entirely.
    set_delays(2, 1);
    dly2[1] = NEVER;
    run_cmd(3'd5, 9'h1FF, 32'h4000_0000, 1'b0);

    // Reset in the middle of an L2 phase.
    set_delays(NEVER, NEVER);
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_mask  = 9'h1FF;
    cmd_addr  = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_l2 req", l2_bus.full_req, 4'hF);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_quiet("post_rst");
    check("post_rst busy",  busy, 0);
    check("post_rst ready", cmd_ready, 1);
    check("post_rst addr",  sel_addr, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_quiet($sformatf("post_rst+%0d", k + 1));
    end

    // Randomized commands.
    for (int n = 0; n < 60; n++) begin
      logic [2:0]         op;
      logic [N_CORES-1:0] mask;
      int                 r;
      r    = $urandom_range(0, 15);
      op   = (r < 14) ? 3'(r % 6) : 3'(6 + (r & 1));
      mask = ($urandom_range(0, 7) == 0) ? '0 : N_CORES'($urandom);
      for (int b = 0; b < N_BANKS; b++) dly2[b] = $urandom_range(0, 5);
      for (int i = 0; i < N_CORES; i++) dly1[i] = $urandom_range(0, 5);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) dly2[$urandom_range(0, N_BANKS - 1)] = NEVER;
        else                           dly1[$urandom_range(0, N_CORES - 1)] = NEVER;
      end
      if ($urandom_range(0, 9) == 0) dly1[$urandom_range(0, N_CORES - 1)] = T_OUT - 1;
      run_cmd(op, mask, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        check($sformatf("gap%0d ready", n), cmd_ready, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
